bus_trace_buf: RTL and testbench
================================

BUS_TRACE_BUF -- requirements
Module: bus_trace_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning trace FIFO entries (power of two, 4..256).
REQ-002 The block SHALL have parameter STALL_LIMIT, default 255, meaning consecutive same-address captures that declare the CPU halted (1..255).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_b  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port enable  input  1  capture qualifier, one bus cycle per asserted clk.
REQ-006 The block SHALL have port addr  input  16  CPU address bus.
REQ-007 The block SHALL have port we  input  1  CPU write enable.
REQ-008 The block SHALL have port wdata  input  8  CPU write data (DO).
REQ-009 The block SHALL have port rdata  input  8  memory read data returned to the CPU (DI).
REQ-010 The block SHALL have port trace_valid  output  1  head entry available.
REQ-011 The block SHALL have port trace_ready  input  1  consumer accepts head entry.
REQ-012 The block SHALL have port trace_ts / trace_addr / trace_data / trace_we  output  16/16/8/1  head entry fields.
REQ-013 The block SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 The block SHALL have port ovf_count  output  8  dropped-capture count.
REQ-015 The block SHALL have port halted  output  1  sticky stall indication.

Function
REQ-016 A 16-bit timestamp counter SHALL increment every clk, wrap 0xFFFF->0x0000, and be sampled into each captured entry.
REQ-017 A capture SHALL be requested on a clk edge where enable=1 and halted=0; entry = {ts, addr, we ? wdata : rdata, we}.
REQ-018 The FIFO SHALL be first-word-fall-through: an entry pushed at edge N SHALL drive trace_valid=1 and the head fields after edge N if the FIFO was empty.
REQ-019 A pop SHALL occur on an edge where trace_valid=1 and trace_ready=1; trace_ready while empty SHALL have no effect.
REQ-020 Push when full SHALL be accepted only if a pop occurs on the same edge; otherwise the capture is dropped and ovf_count increments, saturating at 255.
REQ-021 Simultaneous push and pop SHALL leave level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 The stall detector SHALL compare addr with the last captured addr on each capture: equal -> stall counter +1, different -> stall counter := 0.
REQ-023 halted SHALL assert on the edge where the stall counter reaches STALL_LIMIT and remain set until reset; that final capture SHALL still be pushed.
REQ-024 While halted=1, no further captures SHALL be pushed or counted as overflow; draining SHALL continue normally.
REQ-025 Outputs SHALL be registered or derived only from registers; no combinational path from inputs to trace_valid, level or halted.

Reset
REQ-026 On rst_b=0, asynchronously: FIFO empty, trace_valid=0, head fields 0, level=0, ovf_count=0, halted=0, stall counter 0, timestamp 0, last-address register 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries; the first capture after release SHALL carry ts=0 or the count of cycles since release.
REQ-028 The first capture after reset SHALL never count as a stall match.

Structure
REQ-029 Package trace_pkg SHALL hold trace_entry_t (ts 16, addr 16, data 8, we 1) and constants TRACE_TS_W=16, TRACE_OVF_MAX=255.
REQ-030 Storage SHALL be a sub-module trace_fifo (parameterised DEPTH, payload trace_entry_t, push/pop/full/empty/level); bus_trace_buf holds capture, timestamp, stall and overflow logic.

Verification
REQ-031 Reset, enable=1, addr 0xF000..0xF003 read rdata 0xA9,0x00,0x8D,0x00, trace_ready=1 -> four entries in order, ts consecutive, trace_we=0.
REQ-032 Write addr 0x0200 wdata 0x55 we=1 -> entry trace_data=0x55, trace_we=1 (rdata ignored).
REQ-033 DEPTH=16, trace_ready=0, 20 captures -> level=16, ovf_count=4, first 16 entries drained intact; 300 drops -> ovf_count=255.
REQ-034 Full FIFO, push and pop same edge -> level stays 16, new entry appended, ovf_count unchanged.
REQ-035 STALL_LIMIT=255, addr held at 0xF010 for 256 captures -> halted=1 after 256th capture, later captures ignored, level stops growing.
REQ-036 rst_b pulsed low mid-drain with level=7 -> trace_valid=0, level=0, halted=0, ovf_count=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the CPU bus trace buffer: the captured entry
// layout and the counter limits used by the capture logic.
package trace_pkg;

  localparam int TRACE_TS_W    = 16;
  localparam int TRACE_OVF_MAX = 255;

  typedef struct packed {
    logic [TRACE_TS_W-1:0] ts;
    logic [15:0]           addr;
    logic [7:0]            data;
    logic                  we;
  } trace_entry_t;

  // Writes record what the CPU drove; reads record what memory returned.
  function automatic trace_entry_t make_entry(
    input logic [TRACE_TS_W-1:0] ts,
    input logic [15:0]           addr,
    input logic                  we,
    input logic [7:0]            wdata,
    input logic [7:0]            rdata
  );
    trace_entry_t e;
    e.ts   = ts;
    e.addr = addr;
    e.data = we ? wdata : rdata;
    e.we   = we;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace entries. The head entry is visible as
// soon as it is written; an empty FIFO presents an all-zero head.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   push,
  input  trace_entry_t           push_data,
  input  logic                   pop,
  output trace_entry_t           pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array is deliberately not reset; only pointers and level
  // are, and the head is masked to zero while empty so stale data never shows.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bus_trace_buf.sv
// CPU bus trace buffer: timestamps qualified bus cycles, queues them for a
// consumer, counts drops when the queue overflows and freezes on a CPU stall.
module bus_trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STALL_LIMIT = 255
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   enable,
  input  logic [15:0]            addr,
  input  logic                   we,
  input  logic [7:0]             wdata,
  input  logic [7:0]             rdata,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [15:0]            trace_ts,
  output logic [15:0]            trace_addr,
  output logic [7:0]             trace_data,
  output logic                   trace_we,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             ovf_count,
  output logic                   halted
);

  logic [TRACE_TS_W-1:0] ts;
  logic [15:0]           last_addr;
  logic                  have_last;
  logic [7:0]            stall_cnt;
  logic [7:0]            stall_next;
  logic                  capture;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  drop;
  trace_entry_t          cap_entry;
  trace_entry_t          head;

  assign capture   = enable && !halted;
  assign pop       = trace_valid && trace_ready;
  assign drop      = capture && fifo_full && !pop;
  assign cap_entry = make_entry(ts, addr, we, wdata, rdata);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    stall_next = '0;
    if (have_last && (addr == last_addr)) begin
      stall_next = stall_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  // Stall tracking only advances on captures; the first capture after reset
  // has no predecessor and therefore never matches.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_addr <= '0;
      have_last <= 1'b0;
      stall_cnt <= '0;
      halted    <= 1'b0;
    end else if (capture) begin
      last_addr <= addr;
      have_last <= 1'b1;
      stall_cnt <= stall_next;
      if (stall_next == 8'(STALL_LIMIT)) begin
        halted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_count <= '0;
    end else if (drop && (ovf_count != 8'(TRACE_OVF_MAX))) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (capture),
    .push_data (cap_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign trace_valid = !fifo_empty;
  assign trace_ts    = head.ts;
  assign trace_addr  = head.addr;
  assign trace_data  = head.data;
  assign trace_we    = head.we;

endmodule

// File: tb/tb_bus_trace_buf.sv
// Self-checking bench for bus_trace_buf: directed bus cycles push expected
// entries into a queue that an independent monitor compares at each pop.
module tb_bus_trace_buf;
  import trace_pkg::*;

  localparam int DEPTH       = 16;
  localparam int STALL_LIMIT = 255;

  logic                   clk = 1'b0;
  logic                   rst_b = 1'b0;
  logic                   enable = 1'b0;
  logic [15:0]            addr = '0;
  logic                   we = 1'b0;
  logic [7:0]             wdata = '0;
  logic [7:0]             rdata = '0;
  logic                   trace_valid;
  logic                   trace_ready = 1'b0;
  logic [15:0]            trace_ts;
  logic [15:0]            trace_addr;
  logic [7:0]             trace_data;
  logic                   trace_we;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             ovf_count;
  logic                   halted;

  int           vectors = 0;
  int           miscompares = 0;
  trace_entry_t exp_q[$];
  logic [15:0]  edge_cnt;

  bus_trace_buf #(
    .DEPTH       (DEPTH),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .enable      (enable),
    .addr        (addr),
    .we          (we),
    .wdata       (wdata),
    .rdata       (rdata),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_ts    (trace_ts),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .trace_we    (trace_we),
    .level       (level),
    .ovf_count   (ovf_count),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release: the timestamp a capture must carry.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) edge_cnt <= '0;
    else        edge_cnt <= edge_cnt + 16'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the head is consumed on the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_b && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_entry: got ts=0x%0h addr=0x%0h, want none", trace_ts, trace_addr);
      end else begin
        trace_entry_t e;
        e = exp_q.pop_front();
        check("head_ts",   32'(trace_ts),   32'(e.ts));
        check("head_addr", 32'(trace_addr), 32'(e.addr));
        check("head_data", 32'(trace_data), 32'(e.data));
        check("head_we",   32'(trace_we),   32'(e.we));
      end
    end
  end

  // One qualified bus cycle; exp_data is the hand-derived recorded byte.
  task automatic bus_cycle(input logic [15:0] a, input logic w, input logic [7:0] wd,
                           input logic [7:0] rd, input logic [7:0] exp_data,
                           input logic expect_push);
    trace_entry_t e;
    enable = 1'b1;
    addr   = a;
    we     = w;
    wdata  = wd;
    rdata  = rd;
    if (expect_push) begin
      e.ts   = edge_cnt;
      e.addr = a;
      e.data = exp_data;
      e.we   = w;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    enable = 1'b0;
    we     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    trace_ready = 1'b1;
    while ((exp_q.size() != 0 || level != '0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_level"},      32'(level),        32'd0);
    check({name, "_valid"},      32'(trace_valid),  32'd0);
  endtask

  task automatic do_reset();
    trace_ready = 1'b0;
    enable      = 1'b0;
    rst_b       = 1'b0;
    exp_q.delete();
    #2;
    rst_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic stall_run(input logic [15:0] a, input string name);
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < STALL_LIMIT; i++) bus_cycle(a, 1'b0, 8'h00, 8'hEA, 8'hEA, 1'b1);
    check({name, "_not_yet_halted"}, 32'(halted), 32'd0);
    bus_cycle(a, 1'b0, 8'h00, 8'hEA, 8'hEA, 1'b1);
    check({name, "_halted"}, 32'(halted), 32'd1);
    check({name, "_level_at_halt"}, 32'(level), 32'd1);
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) bus_cycle(a + 16'(i), 1'b0, 8'h00, 8'hEA, 8'hEA, 1'b0);
    check({name, "_level_frozen"}, 32'(level), 32'd1);
    check({name, "_no_ovf"}, 32'(ovf_count), 32'd0);
    wait_drain({name, "_drain"});
    check({name, "_still_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd_addr [4];
    logic [7:0]  rd_data [4];
    rd_addr = '{16'hF000, 16'hF001, 16'hF002, 16'hF003};
    rd_data = '{8'hA9, 8'h00, 8'h8D, 8'h00};

    // Reset state, held from time zero.
    #2;
    check("rst_valid",  32'(trace_valid), 32'd0);
    check("rst_level",  32'(level),       32'd0);
    check("rst_ovf",    32'(ovf_count),   32'd0);
    check("rst_halted", 32'(halted),      32'd0);
    check("rst_head",   {trace_ts, trace_addr}, 32'd0);
    check("rst_head_b", {23'd0, trace_data, trace_we}, 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    idle(2);

    // Four reads with the consumer always ready.
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus_cycle(rd_addr[i], 1'b0, 8'hFF, rd_data[i], rd_data[i], 1'b1);
    wait_drain("reads");

    // Write: the recorded byte is wdata, rdata is ignored.
    bus_cycle(16'h0200, 1'b1, 8'h55, 8'h77, 8'h55, 1'b1);
    wait_drain("write");

    // Fill past capacity with the consumer stalled.
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      bus_cycle(16'h1000 + 16'(i), 1'b0, 8'h00, 8'(i), 8'(i), i < DEPTH);
    check("fill_level", 32'(level),     32'd16);
    check("fill_ovf",   32'(ovf_count), 32'd4);
    check("fill_full_valid", 32'(trace_valid), 32'd1);

    // Push and pop on the same edge while full.
    trace_ready = 1'b1;
    bus_cycle(16'h2000, 1'b0, 8'h00, 8'h3C, 8'h3C, 1'b1);
    trace_ready = 1'b0;
    check("pushpop_level", 32'(level),     32'd16);
    check("pushpop_ovf",   32'(ovf_count), 32'd4);

    // Overflow saturates.
    for (int i = 0; i < 300; i++)
      bus_cycle(16'h3000 + 16'(i), 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    check("sat_ovf",   32'(ovf_count), 32'd255);
    check("sat_level", 32'(level),     32'd16);
    wait_drain("overflow");
    check("sat_ovf_after_drain", 32'(ovf_count), 32'd255);

    // Stall detection, including an address equal to the reset value.
    stall_run(16'hF010, "stall_f010");
    trace_ready = 1'b0;
    #1;
    rst_b = 1'b0;
    #1;
    check("async_rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;
    stall_run(16'h0000, "stall_zero");

    // Asynchronous reset mid-drain.
    do_reset();
    for (int i = 0; i < 20; i++)
      bus_cycle(16'h4000 + 16'(i), 1'b0, 8'h00, 8'(8'h80 + i), 8'(8'h80 + i), i < DEPTH);
    trace_ready = 1'b1;
    idle(9);
    trace_ready = 1'b0;
    check("middrain_level", 32'(level),     32'd7);
    check("middrain_ovf",   32'(ovf_count), 32'd4);
    #1;
    rst_b = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid",  32'(trace_valid), 32'd0);
    check("async_rst_level",  32'(level),       32'd0);
    check("async_rst_ovf",    32'(ovf_count),   32'd0);
    check("async_rst_halted2", 32'(halted),     32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    idle(3);
    // First capture after release carries the edges counted since release.
    bus_cycle(16'h5000, 1'b0, 8'h00, 8'h42, 8'h42, 1'b1);
    wait_drain("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
